seq_det_controller: RTL and testbench

//  Run-control wrapper around a serial pattern detector. Holds a programmable

---
 rtl/seq_det_controller_if.sv | 31 +++
 rtl/seq_det_controller.sv | 153 +++++++++++++++
 tb/tb_seq_det_controller.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_controller_if.sv
// Config/status and serial-input bundle for seq_det_controller.
// The master drives configuration and the stream. The slave (the controller) returns status.
interface seq_det_controller_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [2:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_thresh;
  logic             start;
  logic             stop;
  logic             in;
  logic             in_valid;
  logic             det;
  logic [CNT_W-1:0] count;
  logic             thresh_hit;
  logic             timeout;
  logic             busy;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh, start, stop, in, in_valid,
    input  det, count, thresh_hit, timeout, busy
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh, start, stop, in, in_valid,
    output det, count, thresh_hit, timeout, busy
  );
endinterface

// File: rtl/seq_det_controller.sv
// Run-controlled serial pattern detector with a match counter and a threshold stop.
// Optional macro SEQ_DET_CTRL_TIMEOUT_EN adds an idle-bit timeout that ends the hunt.
module seq_det_controller #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TMO_W = 6
`endif
) (
  input  logic                clk,
  input  logic                rst,
  seq_det_controller_if.slave bus
);

  localparam logic [2:0] PatWL = 3'(PAT_W);

  typedef enum logic [1:0] {StIdle, StHunt, StDone} state_e;

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [2:0]       len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] thr_q;
  // The oldest history bit is never compared, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0] hist_q;
  logic [2:0]       fill_q;
  logic [CNT_W-1:0] count_q;
  logic             thresh_hit_q;

  logic [2:0]       len_eff;
  logic [PAT_W-1:0] window;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-2:0] hist_shift;
  logic [2:0]       fill_inc;
  logic [CNT_W-1:0] count_inc;
  logic             busy;
  logic             det;

`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_inc;
  logic             timeout_q;

  assign tmo_inc = tmo_q + TMO_W'(1);
`endif

  always_comb begin
    len_eff = bus.cfg_len;
    if (bus.cfg_len == 3'd0) begin
      len_eff = 3'd1;
    end else if (bus.cfg_len > PatWL) begin
      len_eff = PatWL;
    end
  end

  always_comb begin
    window = {hist_q, bus.in};
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (3'(i) < len_q);
    end
    busy       = (state_q == StHunt);
    det        = busy & bus.in_valid & (fill_q >= (len_q - 3'd1)) &
                 (((window ^ pat_q) & mask) == '0);
    hist_shift = window[PAT_W-2:0];
    fill_inc   = (fill_q == PatWL) ? fill_q : fill_q + 3'd1;
    count_inc  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pat_q        <= '0;
      len_q        <= 3'd1;
      ovl_q        <= 1'b0;
      thr_q        <= '0;
      hist_q       <= '0;
      fill_q       <= '0;
      count_q      <= '0;
      thresh_hit_q <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      if (bus.cfg_we && (state_q != StHunt)) begin
        pat_q <= bus.cfg_pattern;
        len_q <= len_eff;
        ovl_q <= bus.cfg_overlap;
        thr_q <= bus.cfg_thresh;
      end
      if (bus.stop) begin
        state_q      <= StIdle;
        thresh_hit_q <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
        timeout_q    <= 1'b0;
`endif
      end else if (state_q != StHunt) begin
        if (bus.start) begin
          state_q      <= StHunt;
          count_q      <= '0;
          hist_q       <= '0;
          fill_q       <= '0;
          thresh_hit_q <= 1'b0;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
          tmo_q        <= '0;
          timeout_q    <= 1'b0;
`endif
        end
      end else if (bus.in_valid) begin
        if (det) begin
          count_q <= count_inc;
          if (ovl_q) begin
            hist_q <= hist_shift;
            fill_q <= fill_inc;
          end else begin
            hist_q <= '0;
            fill_q <= '0;
          end
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
          tmo_q <= '0;
`endif
          if ((thr_q != '0) && (count_inc == thr_q)) begin
            state_q      <= StDone;
            thresh_hit_q <= 1'b1;
          end
        end else begin
          hist_q <= hist_shift;
          fill_q <= fill_inc;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
          tmo_q <= tmo_inc;
          if (tmo_inc == '1) begin
            state_q      <= StDone;
            timeout_q    <= 1'b1;
            thresh_hit_q <= 1'b0;
          end
`endif
        end
      end
    end
  end

  assign bus.det        = det;
  assign bus.count      = count_q;
  assign bus.thresh_hit = thresh_hit_q;
  assign bus.busy       = busy;
`ifdef SEQ_DET_CTRL_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_controller.sv
// Scoreboard bench for seq_det_controller: the driver predicts each cycle's outputs from a
// queue-based reference model, and a negedge monitor pops and compares them.
module tb_seq_det_controller;
  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_det_controller_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_det_controller #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct packed {
    logic             det;
    logic [CNT_W-1:0] count;
    logic             thresh_hit;
    logic             busy;
    logic             timeout;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Staged configuration, applied to the bus together with the other inputs.
  logic [PAT_W-1:0] s_pat = '0;
  logic [2:0]       s_len = '0;
  logic             s_ovl = 1'b0;
  logic [CNT_W-1:0] s_thr = '0;

  // Reference model: the mode flags plus a queue of accepted bits since the last clear.
  bit   m_hunt, m_hit, m_ovl;
  int   m_count, m_pat, m_len, m_thr;
  bit   m_hist[$];

  function automatic bit m_match(input bit b);
    bit got;
    if (!m_hunt) return 1'b0;
    if (m_hist.size() < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      got = (k == 0) ? b : m_hist[m_hist.size() - k];
      if (got != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, want);
    end
  endtask

  task automatic set_cfg(input logic [PAT_W-1:0] p, input logic [2:0] l, input bit o,
                         input logic [CNT_W-1:0] t);
    s_pat = p;
    s_len = l;
    s_ovl = o;
    s_thr = t;
  endtask

  task automatic step(input bit r, input bit we, input bit st, input bit sp, input bit b,
                      input bit v);
    obs_t e;
    bit   hit, was_hunt;
    int   l;
    @(posedge clk);
    #1;
    rst_n           = r;
    bus.cfg_we      = we;
    bus.cfg_pattern = s_pat;
    bus.cfg_len     = s_len;
    bus.cfg_overlap = s_ovl;
    bus.cfg_thresh  = s_thr;
    bus.start       = st;
    bus.stop        = sp;
    bus.in          = b;
    bus.in_valid    = v;
    if (!r) begin
      m_hunt = 0; m_hit = 0; m_ovl = 0; m_count = 0; m_pat = 0; m_len = 1; m_thr = 0;
      m_hist.delete();
      e = '0;
      exp_q.push_back(e);
      return;
    end
    hit          = v && m_match(b);
    e.det        = hit;
    e.count      = CNT_W'(m_count);
    e.thresh_hit = m_hit;
    e.busy       = m_hunt;
    e.timeout    = 1'b0;
    exp_q.push_back(e);
    was_hunt = m_hunt;
    if (we && !was_hunt) begin
      l = int'(s_len);
      m_len = (l == 0) ? 1 : ((l > int'(PAT_W)) ? int'(PAT_W) : l);
      m_pat = int'(s_pat);
      m_ovl = s_ovl;
      m_thr = int'(s_thr);
    end
    if (sp) begin
      m_hunt = 0;
      m_hit  = 0;
    end else if (!was_hunt) begin
      if (st) begin
        m_hunt = 1; m_hit = 0; m_count = 0;
        m_hist.delete();
      end
    end else if (v) begin
      if (hit) begin
        if (m_count < (1 << CNT_W) - 1) m_count++;
        if (m_ovl) m_hist.push_back(b);
        else m_hist.delete();
        if (m_thr != 0 && m_count == m_thr) begin
          m_hunt = 0;
          m_hit  = 1;
        end
      end else begin
        m_hist.push_back(b);
      end
      while (m_hist.size() > PAT_W) void'(m_hist.pop_front());
    end
  endtask

  task automatic run_bits(input int n, input logic [15:0] v);
    for (int i = n - 1; i >= 0; i--) step(1, 0, 0, 0, v[i], 1);
  endtask

  task automatic cfg_start();
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
  endtask

  always @(negedge clk) begin : mon
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.det, bus.count, bus.thresh_hit, bus.busy, bus.timeout};
      chk("det", int'(a.det), int'(e.det));
      chk("count", int'(a.count), int'(e.count));
      chk("thresh_hit", int'(a.thresh_hit), int'(e.thresh_hit));
      chk("busy", int'(a.busy), int'(e.busy));
      chk("timeout", int'(a.timeout), int'(e.timeout));
    end
  end

  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_thresh = '0; bus.start = 0; bus.stop = 0; bus.in = 0; bus.in_valid = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // 101, non-overlapping then overlapping, free-run
    set_cfg(4'b0101, 3'd3, 1'b0, 8'd0); cfg_start(); run_bits(5, 16'b10101);
    step(1, 0, 0, 1, 0, 0);
    set_cfg(4'b0101, 3'd3, 1'b1, 8'd0); cfg_start(); run_bits(5, 16'b10101);
    step(1, 0, 0, 1, 0, 0);

    // threshold 2 ends the hunt; trailing bits ignored; restart from DONE
    set_cfg(4'b0101, 3'd3, 1'b1, 8'd2); cfg_start(); run_bits(7, 16'b1010111);
    step(1, 0, 1, 0, 0, 0); run_bits(3, 16'b101);
    step(1, 0, 0, 1, 0, 0);

    // gaps in in_valid are transparent
    set_cfg(4'b0110, 3'd3, 1'b0, 8'd0); cfg_start(); run_bits(2, 16'b11);
    repeat (3) step(1, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
    run_bits(1, 16'b0);
    step(1, 0, 0, 1, 0, 0);

    // async reset mid-hunt wipes shadow config and count
    set_cfg(4'b0101, 3'd3, 1'b0, 8'd0); cfg_start(); run_bits(2, 16'b10);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0); run_bits(1, 16'b1);
    step(1, 0, 0, 1, 0, 0);

    // cfg_we with start uses the new cfg; cfg_we during HUNT is ignored
    set_cfg(4'b0011, 3'd2, 1'b1, 8'd0); step(1, 1, 1, 0, 0, 0);
    run_bits(6, 16'b011110);
    set_cfg(4'b0000, 3'd1, 1'b0, 8'd1); step(1, 1, 0, 0, 1, 1);
    run_bits(4, 16'b0011);
    step(1, 0, 1, 1, 0, 0);

    // length clamping: 0 -> 1, 7 -> PAT_W
    set_cfg(4'b1001, 3'd0, 1'b1, 8'd0); cfg_start(); run_bits(4, 16'b1011);
    step(1, 0, 0, 1, 0, 0);
    set_cfg(4'b1101, 3'd7, 1'b0, 8'd0); cfg_start(); run_bits(8, 16'b11011101);
    step(1, 0, 0, 1, 0, 0);

    // counter saturation in free-run
    set_cfg(4'b0011, 3'd2, 1'b1, 8'd0); cfg_start();
    repeat (270) step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, 0);

    // random traffic
    repeat (3000) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 49) == 0)
        set_cfg(PAT_W'($urandom), 3'($urandom), 1'($urandom), CNT_W'($urandom_range(0, 5)));
      step((r != 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 59) == 0), 1'($urandom), ($urandom_range(0, 4) != 0));
    end

    step(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
